// File: rtl/mux51_scan_ctrl_if.sv
// Handshake bundle for the byte scanner: byte load channel in, serial bit channel out.
// master = the side that offers bytes and consumes bits; slave = the scanner itself.
interface mux51_scan_ctrl_if;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       bit_valid;
  logic       bit_ready;
  logic       bit_data;
  logic       bit_last;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  bit_valid,
    input  bit_data,
    input  bit_last,
    output bit_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output bit_valid,
    output bit_data,
    output bit_last,
    input  bit_ready
  );
endinterface

// File: rtl/mux51_scan_ctrl.sv
// Byte scanner driving an external 8:1 bit mux: holds one byte on mux_in, walks
// mux_sel through all eight positions and streams the mux output with valid/ready.
module mux51_scan_ctrl #(
  parameter int LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mux51_scan_ctrl_if.slave     bus,
  output logic [7:0]           mux_in,
  output logic [2:0]           mux_sel,
  input  logic                 mux_out,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam logic [2:0] FIRST = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [2:0] LAST  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] mux_in_reg, mux_in_next;
  logic [2:0] mux_sel_reg, mux_sel_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;

  logic load_fire;
  logic bit_fire;
  logic at_last;

  // Handshakes are qualified by registered state only, so no input reaches an output.
  assign load_fire = bus.load_valid && (state_reg == IDLE);
  assign bit_fire  = bus.bit_ready  && (state_reg == SHIFT);
  assign at_last   = (mux_sel_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_fire)            state_next = SHIFT;
      SHIFT:   if (bit_fire && at_last)  state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_last   = 1'b0;
    busy           = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.load_ready = 1'b1;
      end
      SHIFT: begin
        bus.bit_valid = 1'b1;
        bus.bit_last  = at_last;
        busy          = 1'b1;
      end
      default: begin
        bus.load_ready = 1'b0;
      end
    endcase
  end

  // Datapath: byte holding register, select walker and completed-frame counter.
  always_comb begin
    mux_in_next    = mux_in_reg;
    mux_sel_next   = mux_sel_reg;
    frame_cnt_next = frame_cnt_reg;
    if (load_fire) begin
      mux_in_next  = bus.load_data;
      mux_sel_next = FIRST;
    end else if (bit_fire) begin
      if (at_last) begin
        mux_sel_next   = FIRST;
        frame_cnt_next = frame_cnt_reg + 8'd1;
      end else if (LSB_FIRST != 0) begin
        mux_sel_next = mux_sel_reg + 3'd1;
      end else begin
        mux_sel_next = mux_sel_reg - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_in_reg    <= 8'h00;
      mux_sel_reg   <= FIRST;
      frame_cnt_reg <= 8'h00;
    end else begin
      mux_in_reg    <= mux_in_next;
      mux_sel_reg   <= mux_sel_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign mux_in       = mux_in_reg;
  assign mux_sel      = mux_sel_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign bus.bit_data = mux_out;

endmodule

// File: doc/mux51_scan_ctrl.md
# mux51_scan_ctrl

Byte scanner that sits directly upstream of the 8:1 bit multiplexer. Accepts one byte over a valid/ready handshake, holds it on the mux data inputs, steps the mux select through all eight positions, and forwards the mux output as a serial bit stream with its own valid/ready handshake. Counts completed bytes for status.

## Interface

- `LSB_FIRST`, default 1: 1 = select order 0→7; 0 = select order 7→0.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_valid` in 1: upstream byte offered.
- `load_ready` out 1: block can accept a byte; high only in IDLE.
- `load_data` in 8: byte to serialize.
- `mux_in` out 8: registered byte, wired to the mux data input.
- `mux_sel` out 3: registered select, wired to the mux select input.
- `mux_out` in 1: mux output, combinational from `mux_in`/`mux_sel`.
- `bit_valid` out 1: serial bit available.
- `bit_ready` in 1: downstream accepts bit.
- `bit_data` out 1: equals `mux_out`.
- `bit_last` out 1: current bit is the 8th of the byte.
- `busy` out 1: high in SHIFT.
- `frame_cnt` out 8: completed-byte counter, wraps 255→0.

## Operation

- States: IDLE, SHIFT.
- Index pattern: FIRST = 0 if `LSB_FIRST` else 7; LAST = 7 if `LSB_FIRST` else 0; step +1 or −1 accordingly.
- IDLE: `load_ready`=1, `bit_valid`=0, `mux_sel`=FIRST. On `load_valid && load_ready`: `mux_in` ← `load_data`, `mux_sel` ← FIRST, go to SHIFT.
- SHIFT: `load_ready`=0, `busy`=1, `bit_valid`=1, `bit_data`=`mux_out`, `bit_last`=(`mux_sel`==LAST).
  - Transfer = `bit_valid && bit_ready`.
  - Transfer with `bit_last`=0: `mux_sel` steps by one.
  - Transfer with `bit_last`=1: go to IDLE, `mux_sel` ← FIRST, `frame_cnt` ← `frame_cnt`+1 (mod 256).
  - No transfer: `mux_in`, `mux_sel`, and therefore `bit_data` held stable; `bit_valid` must not drop.
- `load_valid` ignored in SHIFT; the offered byte is not consumed.
- `bit_ready` ignored in IDLE.
- `bit_last` is 0 whenever `bit_valid` is 0.
- Reset values, asynchronous on `rst`: state IDLE, `mux_in`=8'h00, `mux_sel`=FIRST, `frame_cnt`=0. Hence `load_ready`=1, `bit_valid`=0, `bit_last`=0, `busy`=0.
- Reset mid-SHIFT: byte abandoned, no `bit_last` emitted, `frame_cnt` not incremented.

## Timing

- Load accepted at edge N: SHIFT from cycle N+1, first bit valid in cycle N+1.
- With `bit_ready` held high:
  - Bits in cycles N+1..N+8; `bit_last` in cycle N+8.
  - IDLE and `load_ready`=1 in cycle N+9; `frame_cnt` updated in cycle N+9.
  - Sustained throughput: one byte per 9 cycles.
- Each cycle with `bit_ready` low in SHIFT extends the frame by exactly one cycle.
- `bit_data` has one combinational mux delay from the registered `mux_in`/`mux_sel`. No registered stage is added in this block.
- All other outputs are registered or decoded from registered state only. There is no combinational path from `load_valid` or `bit_ready` to any output.

## Test plan

- `LSB_FIRST`=1, load 8'hA5 at edge N, `bit_ready`=1 → `bit_data` 1,0,1,0,0,1,0,1 in cycles N+1..N+8; `bit_last` only in N+8; `load_ready`=1 and `frame_cnt`=1 in N+9.
- `LSB_FIRST`=0, load 8'hA5 → `bit_data` 1,0,1,0,0,1,0,1 with `mux_sel` 7→0; load 8'h01 → seven 0s, then 1 with `bit_last`=1.
- Backpressure: load 8'h3C, drop `bit_ready` for 3 cycles at bit index 2 → `mux_sel`=2 and `bit_data`=1 held throughout; frame completes in 11 cycles; stream 0,0,1,1,1,1,0,0.
- `load_valid`=1 with 8'hFF while SHIFTing 8'h00 → `load_ready`=0; output stays all 0s; 8'hFF is accepted only in the IDLE cycle after `bit_last`.
- Assert `rst` at bit index 4 of 8'h5A → asynchronously `bit_valid`=0, `mux_sel`=FIRST, `mux_in`=0, `frame_cnt` unchanged at 0; the next byte serializes correctly.
- Send 256 back-to-back bytes → `frame_cnt` 255 then 0; 257th byte → `frame_cnt`=1.
